ball_mover: RTL

- Owns the ball (square) in breakout mode and moves it one step per animation strobe.
- Reflects the ball off the walls and the paddle, and publishes its centre (s_x, s_y) to every block instance.
- Consumes the OR of all blocks' hit codes and acknowledges each hit with col_detected.
- Tracks lives and reports ball loss and game over to the top level.

---
 rtl/ball_mover.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ball_mover.sv
// Breakout ball: steps the ball on each animation strobe, bounces it off walls, paddle and blocks, and tracks lives.
// Build option BALL_SPEEDUP_EN: the ball speeds up every SPEEDUP_N paddle bounces, up to MAX_SPEED.
module ball_mover #(
    parameter int S_SIZE    = 5,
    parameter int IX        = 320,
    parameter int IY        = 440,
    parameter int D_WIDTH   = 640,
    parameter int D_HEIGHT  = 480,
    parameter int SPEED     = 1,
    parameter int BUFF      = 2,
    parameter int LIVES     = 3,
    parameter int SPEEDUP_N = 8,
    parameter int MAX_SPEED = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        mode,
    input  logic        start,
    input  logic [1:0]  hit_block,
    input  logic [11:0] i_x1,
    input  logic [11:0] i_x2,
    input  logic [11:0] i_py1,
    output logic [11:0] s_x,
    output logic [11:0] s_y,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic        col_detected,
    output logic        o_x_dir,
    output logic        o_y_dir,
    output logic        o_lost,
    output logic [1:0]  lives,
    output logic        game_over
);
    // state | meaning
    // IDLE  | ball parked on the paddle, waiting for start
    // RUN   | ball in play, block hits accepted
    // ACK   | block hit acknowledged, waiting for hit_block to clear
    // OVER  | no lives left, frozen until mode drops
    typedef enum logic [1:0] {IDLE, RUN, ACK, OVER} state_t;

    state_t      state, state_nxt;
    logic [11:0] s_x_nxt, s_y_nxt;
    logic        x_dir_nxt, y_dir_nxt, col_nxt, lost_nxt, game_over_nxt;
    logic [1:0]  lives_nxt;
    logic [11:0] speed;
`ifdef BALL_SPEEDUP_EN
    logic [11:0] speed_nxt;
    logic [7:0]  bounce_q, bounce_nxt;
`else
    assign speed = 12'(SPEED);
`endif

    logic [12:0] x_w, y_w, spd_w, py_w;
    logic [11:0] centre_x;
    logic        wall_x, wall_t, pad_hit, out_bottom, move;

    assign x_w   = {1'b0, s_x};
    assign y_w   = {1'b0, s_y};
    assign spd_w = {1'b0, speed};
    assign py_w  = {1'b0, i_py1};

    // All comparisons run one bit wider so sums near 4095 cannot wrap.
    assign wall_x     = o_x_dir ? (x_w + 13'(S_SIZE) + spd_w >= 13'(D_WIDTH))
                                : (x_w <= 13'(S_SIZE) + spd_w);
    assign wall_t     = !o_y_dir && (y_w <= 13'(S_SIZE) + spd_w);
    assign pad_hit    = o_y_dir && (y_w + 13'(S_SIZE) >= py_w)
                        && (y_w + 13'(S_SIZE) <= py_w + 13'(BUFF))
                        && (s_x >= i_x1) && (s_x <= i_x2);
    assign out_bottom = y_w >= 13'(D_HEIGHT - S_SIZE);
    assign move       = i_ani_stb && i_animate;
    assign centre_x   = 12'((13'(i_x1) + 13'(i_x2)) >> 1);

    assign o_x1 = s_x - 12'(S_SIZE);
    assign o_x2 = s_x + 12'(S_SIZE);
    assign o_y1 = s_y - 12'(S_SIZE);
    assign o_y2 = s_y + 12'(S_SIZE);

    always_comb begin
        state_nxt     = state;
        s_x_nxt       = s_x;
        s_y_nxt       = s_y;
        x_dir_nxt     = o_x_dir;
        y_dir_nxt     = o_y_dir;
        col_nxt       = col_detected;
        lost_nxt      = 1'b0;
        lives_nxt     = lives;
        game_over_nxt = game_over;
`ifdef BALL_SPEEDUP_EN
        speed_nxt     = speed;
        bounce_nxt    = bounce_q;
`endif
        if (!mode) begin
            state_nxt     = IDLE;
            s_x_nxt       = 12'(IX);
            s_y_nxt       = 12'(IY);
            x_dir_nxt     = 1'b1;
            y_dir_nxt     = 1'b0;
            col_nxt       = 1'b0;
            lives_nxt     = 2'(LIVES);
            game_over_nxt = 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed_nxt     = 12'(SPEED);
            bounce_nxt    = 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    s_x_nxt   = centre_x;
                    s_y_nxt   = i_py1 - 12'(S_SIZE + 1);
                    x_dir_nxt = 1'b1;
                    y_dir_nxt = 1'b0;
                    col_nxt   = 1'b0;
                    if (start) state_nxt = RUN;
                end
                RUN, ACK: begin
                    if (out_bottom) begin
                        lost_nxt  = 1'b1;
                        lives_nxt = lives - 2'd1;
                        col_nxt   = 1'b0;
`ifdef BALL_SPEEDUP_EN
                        speed_nxt = 12'(SPEED);
`endif
                        if (lives == 2'd1) begin
                            game_over_nxt = 1'b1;
                            state_nxt     = OVER;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (state == RUN && hit_block != 2'b00 && !col_detected) begin
                        // A block hit swallows any strobe in the same cycle.
                        if (hit_block[1]) x_dir_nxt = !o_x_dir;
                        if (hit_block[0]) y_dir_nxt = !o_y_dir;
                        col_nxt   = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        if (state == ACK && hit_block == 2'b00) begin
                            col_nxt   = 1'b0;
                            state_nxt = RUN;
                        end
                        if (move) begin
                            if (wall_x) x_dir_nxt = !o_x_dir;
                            else if (o_x_dir) s_x_nxt = s_x + speed;
                            else s_x_nxt = s_x - speed;
                            if (wall_t || pad_hit) y_dir_nxt = !o_y_dir;
                            else if (o_y_dir) s_y_nxt = s_y + speed;
                            else s_y_nxt = s_y - speed;
`ifdef BALL_SPEEDUP_EN
                            if (pad_hit) begin
                                if (bounce_q + 8'd1 >= 8'(SPEEDUP_N)) begin
                                    bounce_nxt = 8'd0;
                                    if (speed < 12'(MAX_SPEED)) speed_nxt = speed + 12'd1;
                                end else begin
                                    bounce_nxt = bounce_q + 8'd1;
                                end
                            end
`endif
                        end
                    end
                end
                OVER: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            s_x          <= 12'(IX);
            s_y          <= 12'(IY);
            o_x_dir      <= 1'b1;
            o_y_dir      <= 1'b0;
            col_detected <= 1'b0;
            o_lost       <= 1'b0;
            lives        <= 2'(LIVES);
            game_over    <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed        <= 12'(SPEED);
            bounce_q     <= 8'd0;
`endif
        end else begin
            state        <= state_nxt;
            s_x          <= s_x_nxt;
            s_y          <= s_y_nxt;
            o_x_dir      <= x_dir_nxt;
            o_y_dir      <= y_dir_nxt;
            col_detected <= col_nxt;
            o_lost       <= lost_nxt;
            lives        <= lives_nxt;
            game_over    <= game_over_nxt;
`ifdef BALL_SPEEDUP_EN
            speed        <= speed_nxt;
            bounce_q     <= bounce_nxt;
`endif
        end
    end
endmodule
